serial_mul_checker: RTL and testbench

SERIAL_MUL_CHECKER -- requirements
Module: serial_mul_checker

---
 rtl/serial_mul_checker.sv | 180 ++++++++++++++++++
 tb/tb_serial_mul_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mul_checker.sv
// serial_mul_checker: receives UART-style result frames on serial_in and checks
// each one against hi*lo (or hi+lo) of a sweeping operand counter.
// Optional build macro HALT_ON_FAIL_EN: first failing frame ends the sweep.
module serial_mul_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned OP_MODE   = 0,
  parameter int unsigned START_ARG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH:0]   frame_cnt,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] last_data,
  output logic [WIDTH-1:0] fail_arg
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH:0]   CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] ARG_INIT  = WIDTH'(START_ARG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] arg;
  logic             frame_err;

  logic [HALF-1:0]  op_hi;
  logic [HALF-1:0]  op_lo;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             err_now;
  logic             arg_wrap;
  logic [WIDTH:0]   err_cnt_inc;
  logic [WIDTH:0]   frame_cnt_inc;

  assign op_hi = arg[WIDTH-1:HALF];
  assign op_lo = arg[HALF-1:0];

  // Expected frame value derived from the current operand counter.
  always_comb begin
    expected = '0;
    if (OP_MODE == 1) expected = WIDTH'(op_hi) + WIDTH'(op_lo);
    else              expected = WIDTH'(op_hi) * WIDTH'(op_lo);
  end

  assign mismatch      = (shift_reg != expected);
  assign err_now       = mismatch | frame_err;
  assign arg_wrap      = &arg;
  assign err_cnt_inc   = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + (WIDTH+1)'(1);
  assign frame_cnt_inc = (frame_cnt == CNT_MAX) ? frame_cnt : frame_cnt + (WIDTH+1)'(1);

  // Receive/check FSM with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      arg       <= ARG_INIT;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      last_data <= '0;
      fail_arg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && !serial_in) begin
            state   <= S_START;
            busy    <= 1'b1;
            div_cnt <= '0;
          end
        end

        S_START: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (serial_in) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= S_DATA;
              bit_cnt   <= '0;
              frame_err <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            shift_reg <= {serial_in, shift_reg[WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) state <= S_STOP;
            else                     bit_cnt <= bit_cnt + BIT_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_STOP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= S_CHECK;
            if (!serial_in) begin
              frame_err <= 1'b1;
              err_cnt   <= err_cnt_inc;
              fail      <= 1'b1;
              if (!fail) fail_arg <= arg;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        S_CHECK: begin
          frame_cnt <= frame_cnt_inc;
          last_data <= shift_reg;
          arg       <= arg + WIDTH'(1);
          busy      <= 1'b0;
          // A framing error was already counted in STOP; count a frame once.
          if (mismatch && !frame_err) begin
            err_cnt <= err_cnt_inc;
            fail    <= 1'b1;
            if (!fail) fail_arg <= arg;
          end
`ifdef HALT_ON_FAIL_EN
          if (arg_wrap || err_now) begin
`else
          if (arg_wrap) begin
`endif
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !err_now;
          end else begin
            state <= S_IDLE;
          end
        end

        S_DONE: begin
          state <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mul_checker.sv
// Scoreboard bench for serial_mul_checker (WIDTH=8, CLK_DIV=4, product mode).
module tb_serial_mul_checker;

  localparam int unsigned W   = 8;
  localparam int unsigned DIV = 4;

  logic         clk;
  logic         rst_n;
  logic         serial_in;
  logic         enable;
  logic         busy;
  logic         done;
  logic         pass;
  logic         fail;
  logic [W:0]   frame_cnt;
  logic [W:0]   err_cnt;
  logic [W-1:0] last_data;
  logic [W-1:0] fail_arg;

  serial_mul_checker #(
    .WIDTH(W),
    .CLK_DIV(DIV),
    .OP_MODE(0),
    .START_ARG(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .serial_in(serial_in),
    .enable(enable),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail(fail),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
    .last_data(last_data),
    .fail_arg(fail_arg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] frames;
    logic [8:0] errs;
    logic [7:0] last;
    logic [7:0] farg;
    logic       fail;
    logic       done;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Frame-level reference model of the checker.
  int unsigned m_arg, m_frames, m_errs, m_last, m_fail_arg;
  bit          m_fail, m_done;

  function automatic logic [7:0] ref_val(input int unsigned a);
    return 8'((a / 16) * (a % 16));
  endfunction

  task automatic model_reset();
    m_arg = 0; m_frames = 0; m_errs = 0; m_last = 0; m_fail_arg = 0;
    m_fail = 0; m_done = 0;
  endtask

  task automatic push_snapshot();
    exp_t e;
    e.frames = 9'(m_frames);
    e.errs   = 9'(m_errs);
    e.last   = 8'(m_last);
    e.farg   = 8'(m_fail_arg);
    e.fail   = m_fail;
    e.done   = m_done;
    e.pass   = m_done && (m_errs == 0);
    sb.push_back(e);
  endtask

  task automatic model_frame(input logic [7:0] data, input bit stop_ok);
    bit bad;
    if (m_done) return;
    bad = (data != ref_val(m_arg)) || !stop_ok;
    if (m_frames < 511) m_frames++;
    m_last = data;
    if (bad) begin
      if (m_errs < 511) m_errs++;
      if (!m_fail) m_fail_arg = m_arg;
      m_fail = 1;
    end
    m_arg = (m_arg + 1) % 256;
    if (m_arg == 0) m_done = 1;
`ifdef HALT_ON_FAIL_EN
    if (bad) m_done = 1;
`endif
    push_snapshot();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy 1->0 transition is a completed frame or rejected glitch.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_end actual=busy_fell expected=no_event at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("frame_cnt", 32'(frame_cnt), 32'(e.frames));
          chk("err_cnt",   32'(err_cnt),   32'(e.errs));
          chk("last_data", 32'(last_data), 32'(e.last));
          chk("fail_arg",  32'(fail_arg),  32'(e.farg));
          chk("fail",      32'(fail),      32'(e.fail));
          chk("done",      32'(done),      32'(e.done));
          chk("pass",      32'(pass),      32'(e.pass));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] data, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    model_frame(data, stop);
    drive_frame(data, stop);
  endtask

  task automatic send_glitch();
    if (!m_done) push_snapshot();
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_pass"},      32'(pass),      0);
    chk({tag, "_fail"},      32'(fail),      0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   0);
    chk({tag, "_last_data"}, 32'(last_data), 0);
    chk({tag, "_fail_arg"},  32'(fail_arg),  0);
  endtask

  task automatic do_reset();
    serial_in = 1'b1;
    enable    = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int unsigned r;
    int unsigned n;

    rst_n = 1'b0;
    serial_in = 1'b1;
    enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sweep of correct products, frames back-to-back.
    for (int a = 0; a < 256; a++) send_frame(ref_val(m_arg), 1'b1);
    wait_drain();
    chk("sweep_done",      32'(done),      32'(m_done));
    chk("sweep_pass",      32'(pass),      32'(m_done && m_errs == 0));
    chk("sweep_frame_cnt", 32'(frame_cnt), 32'(m_frames));
    // DONE ignores further frames.
    drive_frame(8'h00, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    chk("done_hold_busy",  32'(busy),      0);
    chk("done_hold_frame", 32'(frame_cnt), 32'(m_frames));

    // Framing error on a correct frame, then a data mismatch.
    do_reset();
    send_frame(ref_val(0), 1'b0);
    send_frame(8'h55, 1'b1);
    wait_drain();

    // Reset in the middle of data bit 3, then recovery.
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    serial_in = d[3];
    repeat (2) @(negedge clk);
    chk("midframe_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("midrst");
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    model_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(ref_val(m_arg), 1'b1);
    send_glitch();
    send_frame(ref_val(m_arg), 1'b1);
    wait_drain();

    // Randomized sweep: clean up to 0x22, wrong value at 0x23, random faults after.
    do_reset();
    n = 0;
    while (!m_done && n < 600) begin
      n++;
      r = $urandom_range(0, 15);
      if (m_arg < 8'h23) begin
        if (r == 0) begin
          enable = 1'b0;
          drive_frame(8'($urandom), 1'b1);
          enable = 1'b1;
        end else if (r < 3) begin
          send_glitch();
        end else begin
          send_frame(ref_val(m_arg), 1'b1);
        end
      end else if (m_arg == 8'h23) begin
        send_frame(8'h07, 1'b1);
      end else if (r < 4) begin
        send_frame(ref_val(m_arg) ^ 8'($urandom_range(1, 255)), 1'b1);
      end else if (r < 6) begin
        send_frame(ref_val(m_arg), 1'b0);
      end else if (r == 6) begin
        send_glitch();
      end else begin
        send_frame(ref_val(m_arg), 1'b1);
      end
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
    end
    wait_drain();
    chk("final_done", 32'(done), 32'(m_done));
    chk("final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
